// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the two-port cache-to-memory arbiter.
package mem_arbiter_pkg;

    // Default widths and timeout
    localparam int DEF_ADDR_W  = 32;
    localparam int DEF_DATA_W  = 256;
    localparam int DEF_TIMEOUT = 64;

    // Port index constants (p0 = icache, p1 = dcache)
    localparam int P0 = 0;
    localparam int P1 = 1;

    // Arbiter FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-requester round-robin pick: a lone requester wins outright, a tie goes
// to the port that was not granted last. Purely combinational.
module rr_arb2
    import mem_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,   // 0 = p0 granted last, 1 = p1 granted last
    output logic [1:0] grant         // one-hot, bit P0 / bit P1
);

    // Select the winner from the request pair and the last owner
    // NOTE: grant gets a default before the case so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        grant = 2'b00;
        unique case (req)
            2'b01:   grant[P0] = 1'b1;
            2'b10:   grant[P1] = 1'b1;
            2'b11:   grant     = (last_grant == 1'(P1)) ? 2'b01 : 2'b10;
            default: grant     = 2'b00;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates icache (p0) and dcache (p1) line requests onto one memory port.
// IDLE latches the winner's request, WAIT holds it on the memory bus until
// mem_ack_i or timeout, RESP returns a one-cycle ack. Every output is a flop.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int TIMEOUT = DEF_TIMEOUT
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              p0_req_i,
    input  logic              p0_write_i,
    input  logic [ADDR_W-1:0] p0_addr_i,
    input  logic [DATA_W-1:0] p0_data_i,
    output logic [DATA_W-1:0] p0_data_o,
    output logic              p0_ack_o,
    input  logic              p1_req_i,
    input  logic              p1_write_i,
    input  logic [ADDR_W-1:0] p1_addr_i,
    input  logic [DATA_W-1:0] p1_data_i,
    output logic [DATA_W-1:0] p1_data_o,
    output logic              p1_ack_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    input  logic [DATA_W-1:0] mem_data_i,
    input  logic              mem_ack_i,
    output logic [1:0]        grant_o,
    output logic              err_o
);

    localparam int              CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_e            r_state,  w_state_n;
    logic [CNT_W-1:0]  r_cnt,    w_cnt_n;
    logic              r_last,   w_last_n;     // port granted most recently
    logic              r_owner,  w_owner_n;    // port owning the current transaction
    logic [1:0]        w_rr_grant;

    logic              w_mem_enable_n, w_mem_write_n, w_err_n;
    logic              w_p0_ack_n, w_p1_ack_n;
    logic [ADDR_W-1:0] w_mem_addr_n;
    logic [DATA_W-1:0] w_mem_data_n, w_p0_data_n, w_p1_data_n;
    logic [1:0]        w_grant_n;

    rr_arb2 u_rr_arb2 (
        .req        ({p1_req_i, p0_req_i}),
        .last_grant (r_last),
        .grant      (w_rr_grant)
    );

    // Next-state and next-output logic; every register holds unless told otherwise
    always_comb begin
        w_state_n      = r_state;
        w_cnt_n        = r_cnt;
        w_last_n       = r_last;
        w_owner_n      = r_owner;
        w_mem_enable_n = mem_enable_o;
        w_mem_write_n  = mem_write_o;
        w_mem_addr_n   = mem_addr_o;
        w_mem_data_n   = mem_data_o;
        w_grant_n      = grant_o;
        w_err_n        = err_o;
        w_p0_data_n    = p0_data_o;
        w_p1_data_n    = p1_data_o;
        w_p0_ack_n     = 1'b0;
        w_p1_ack_n     = 1'b0;

        unique case (r_state)
            ST_IDLE: begin
                w_grant_n      = 2'b00;
                w_mem_enable_n = 1'b0;
                if (|w_rr_grant) begin
                    w_owner_n      = w_rr_grant[P1];
                    w_last_n       = w_rr_grant[P1];
                    w_mem_write_n  = w_rr_grant[P1] ? p1_write_i : p0_write_i;
                    w_mem_addr_n   = w_rr_grant[P1] ? p1_addr_i  : p0_addr_i;
                    w_mem_data_n   = w_rr_grant[P1] ? p1_data_i  : p0_data_i;
                    w_mem_enable_n = 1'b1;
                    w_grant_n      = w_rr_grant;
                    w_cnt_n        = '0;
                    w_state_n      = ST_WAIT;
                end
            end

            ST_WAIT: begin
                if (mem_ack_i || (r_cnt == CNT_LAST)) begin
                    // Timeout completes the transaction without touching read data
                    if (mem_ack_i && !mem_write_o) begin
                        if (r_owner == 1'(P1)) w_p1_data_n = mem_data_i;
                        else                   w_p0_data_n = mem_data_i;
                    end
                    if (!mem_ack_i) w_err_n = 1'b1;
                    w_mem_enable_n = 1'b0;
                    w_p0_ack_n     = (r_owner == 1'(P0));
                    w_p1_ack_n     = (r_owner == 1'(P1));
                    w_state_n      = ST_RESP;
                end else begin
                    w_cnt_n = r_cnt + CNT_W'(1);
                end
            end

            ST_RESP: begin
                w_grant_n = 2'b00;
                w_state_n = ST_IDLE;
            end

            default: begin
                w_grant_n      = 2'b00;
                w_mem_enable_n = 1'b0;
                w_state_n      = ST_IDLE;
            end
        endcase
    end

    // State and output registers with asynchronous active-low clear
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the wide read-data registers are cleared too, because they are visible outputs that must read 0 in reset.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_last       <= 1'(P1);
            r_owner      <= 1'(P0);
            mem_enable_o <= 1'b0;
            mem_write_o  <= 1'b0;
            mem_addr_o   <= '0;
            mem_data_o   <= '0;
            grant_o      <= 2'b00;
            err_o        <= 1'b0;
            p0_ack_o     <= 1'b0;
            p1_ack_o     <= 1'b0;
            p0_data_o    <= '0;
            p1_data_o    <= '0;
        end else begin
            r_state      <= w_state_n;
            r_cnt        <= w_cnt_n;
            r_last       <= w_last_n;
            r_owner      <= w_owner_n;
            mem_enable_o <= w_mem_enable_n;
            mem_write_o  <= w_mem_write_n;
            mem_addr_o   <= w_mem_addr_n;
            mem_data_o   <= w_mem_data_n;
            grant_o      <= w_grant_n;
            err_o        <= w_err_n;
            p0_ack_o     <= w_p0_ack_n;
            p1_ack_o     <= w_p1_ack_n;
            p0_data_o    <= w_p0_data_n;
            p1_data_o    <= w_p1_data_n;
        end
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, 32, memory address width.
REQ-002 SHALL have parameter DATA_W, 256, cache-line data width.
REQ-003 SHALL have parameter TIMEOUT, 64, maximum WAIT cycles before a transaction is flagged.
REQ-004 SHALL have port clk_i  input  1  single clock, all state on rising edge.
REQ-005 SHALL have port rst_i  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports p0_req_i/p1_req_i  input  1  request; p0 = icache, p1 = dcache.
REQ-007 SHALL have ports p0_write_i/p1_write_i  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports p0_addr_i/p1_addr_i  input  ADDR_W  line address.
REQ-009 SHALL have ports p0_data_i/p1_data_i  input  DATA_W  write data.
REQ-010 SHALL have ports p0_data_o/p1_data_o  output  DATA_W  read data, valid with ack.
REQ-011 SHALL have ports p0_ack_o/p1_ack_o  output  1  one-cycle completion pulse.
REQ-012 SHALL have port mem_enable_o  output  1  memory request.
REQ-013 SHALL have port mem_write_o  output  1  memory write strobe.
REQ-014 SHALL have port mem_addr_o  output  ADDR_W  memory address.
REQ-015 SHALL have port mem_data_o  output  DATA_W  memory write data.
REQ-016 SHALL have port mem_data_i  input  DATA_W  memory read data.
REQ-017 SHALL have port mem_ack_i  input  1  memory completion.
REQ-018 SHALL have port grant_o  output  2  one-hot current owner, 00 when idle.
REQ-019 SHALL have port err_o  output  1  sticky timeout flag.

Function
REQ-020 SHALL implement FSM with states IDLE, WAIT and RESP; all outputs are registered.
REQ-021 In IDLE with any pN_req_i high, SHALL latch the granted port's write, addr and data, then enter WAIT on the next edge.
REQ-022 SHALL grant a lone requester immediately; on a tie it SHALL grant the port not granted last (round-robin), with last_grant resetting to p1 so p0 wins the first tie.
REQ-023 In WAIT, SHALL hold mem_enable_o=1 and keep mem_write_o, mem_addr_o and mem_data_o stable at the latched values.
REQ-024 In WAIT, on mem_ack_i=1 SHALL capture mem_data_i (reads only), drop mem_enable_o and enter RESP.
REQ-025 In RESP, SHALL pulse the owner's pN_ack_o for exactly one cycle with pN_data_o valid, then return to IDLE.
REQ-026 pN_data_o SHALL hold its last read value; write completions SHALL NOT alter it.
REQ-027 A requester SHALL hold its req, addr and data until its ack; request changes during WAIT or RESP SHALL be ignored.
REQ-028 mem_ack_i SHALL be ignored in IDLE and RESP.
REQ-029 Latency: req seen at edge N gives mem_enable_o=1 in cycle N+1; mem_ack_i seen at edge M gives pN_ack_o=1 in cycle M+1.
REQ-030 A request from the losing port SHALL stay pending and SHALL be granted in the IDLE cycle after RESP, giving a minimum 1-cycle gap between transactions.
REQ-031 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle.
REQ-032 When the wait counter reaches TIMEOUT-1 without ack, SHALL set err_o and enter RESP, acking the owner with pN_data_o unchanged.
REQ-033 err_o SHALL remain set until reset.
REQ-034 grant_o SHALL show the owner during WAIT and RESP and be 00 in IDLE.

Reset
REQ-035 While rst_i=0, SHALL force state=IDLE, all outputs=0, pN_data_o=0, counter=0 and last_grant=p1, asynchronously.
REQ-036 Reset during WAIT SHALL abandon the transaction with no ack; mem_enable_o falls immediately.
REQ-037 Reset release SHALL take effect on the first rising clk_i edge after rst_i rises.

Structure
REQ-038 A shared package SHALL hold the state enum, the port index constants P0/P1 and the default widths.
REQ-039 The round-robin pick SHALL be one sub-module, rr_arb2 (req[1:0], last_grant in, one-hot grant out, combinational).

Verification
REQ-040 p1 read addr 0x400; mem_ack_i at the 10th WAIT cycle with data 0xA5..A5 -> p1_ack_o single pulse next cycle, p1_data_o=0xA5..A5, grant_o=10 throughout.
REQ-041 p0 and p1 request in the same cycle after reset -> p0 served first, p1 granted in the IDLE cycle after p0's RESP.
REQ-042 p0 write addr 0x80, data 0x1234 -> mem_write_o=1, mem_addr_o=0x80, mem_data_o=0x1234 stable until ack; p0_data_o unchanged.
REQ-043 mem_ack_i withheld, TIMEOUT=64 -> after 64 WAIT cycles err_o=1 and owner ack pulses; err_o stays 1 until rst_i=0.
REQ-044 rst_i low during WAIT -> mem_enable_o=0 immediately, no pN_ack_o; a fresh request after release completes normally.
